// File: rtl/xdisp_arb_pkg.sv
// rtl/xdisp_arb_pkg.sv - shared data width and drain FSM encodings for xdisp_arb
package xdisp_arb_pkg;

  localparam int DATA_W = 12;
  localparam int CNT_W  = 16;
  localparam int GAP_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/xdisp_fifo.sv
// rtl/xdisp_fifo.sv - power-of-two circular FIFO with occupancy count and head output
module xdisp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == L_FULL);
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage array; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally at DEPTH; count holds on simultaneous push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/xdisp_arb.sv
// rtl/xdisp_arb.sv - two-requester round-robin character arbiter draining a FIFO to a display sink; XDISP_ARB_CNT_EN enables char_cnt
module xdisp_arb
  import xdisp_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int GAP   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              disp_sel,
  output logic [DATA_W-1:0] disp_data,
  output logic              busy,
  output logic [CNT_W-1:0]  char_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [GAP_W-1:0] L_GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  state_t            r_state;
  state_t            w_next;
  logic              r_rr;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_push;
  logic              w_pop;
  logic              w_more;
  logic [DATA_W-1:0] w_push_data;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;
  logic [AW:0]       w_count;

  // rr selects requester 1 only when both are valid; a full FIFO blocks everyone
  assign w_grant1    = req1_valid && (!req0_valid || r_rr);
  assign w_grant0    = req0_valid && !w_grant1;
  assign req0_ready  = w_grant0 && !w_full;
  assign req1_ready  = w_grant1 && !w_full;
  assign w_push      = req0_ready || req1_ready;
  assign w_push_data = req1_ready ? req1_data : req0_data;
  assign w_pop       = (r_state == ST_SEND);
  // FIFO still holds something after this cycle's pop (a same-cycle push counts)
  assign w_more      = (w_count > (AW+1)'(1)) || w_push;

  xdisp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Round-robin pointer flips after every accepted character
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_rr <= 1'b0;
    else if (w_push) r_rr <= ~r_rr;
  end

  // Drain FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Drain FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (!w_empty) w_next = ST_SEND;
      ST_SEND: begin
        if (GAP > 0)     w_next = ST_WAIT;
        else if (w_more) w_next = ST_SEND;
        else             w_next = ST_IDLE;
      end
      ST_WAIT: if (r_gap_cnt == '0) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Gap down-counter: loaded on SEND so WAIT spans exactly GAP cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          r_gap_cnt <= '0;
    else if (r_state == ST_SEND)                      r_gap_cnt <= L_GAP_LOAD;
    else if (r_state == ST_WAIT && r_gap_cnt != '0)   r_gap_cnt <= r_gap_cnt - 1'b1;
  end

  // Drain FSM outputs; data is forced to zero outside the select pulse
  always_comb begin
    disp_sel  = (r_state == ST_SEND);
    disp_data = disp_sel ? w_head : '0;
    busy      = !w_empty || (r_state != ST_IDLE);
  end

`ifdef XDISP_ARB_CNT_EN
  logic [CNT_W-1:0] r_char_cnt;

  // Count every SEND cycle, wrapping at the counter width
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_char_cnt <= '0;
    else if (r_state == ST_SEND) r_char_cnt <= r_char_cnt + 1'b1;
  end

  assign char_cnt = r_char_cnt;
`else
  assign char_cnt = '0;
`endif

endmodule

// File: tb/tb_xdisp_arb.sv
// tb/tb_xdisp_arb.sv - directed self-checking bench for xdisp_arb (GAP=2, GAP=3, GAP=0 instances)
module tb_xdisp_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 [3];
  logic        v1 [3];
  logic [11:0] d0 [3];
  logic [11:0] d1 [3];
  logic        r0 [3];
  logic        r1 [3];
  logic        sel [3];
  logic [11:0] dd [3];
  logic        bsy [3];
  logic [15:0] cnt [3];

  int n_pass = 0;
  int n_tot  = 0;

`ifdef XDISP_ARB_CNT_EN
  localparam int EXP_CNT1 = 1;
  localparam int EXP_CNT5 = 5;
`else
  localparam int EXP_CNT1 = 0;
  localparam int EXP_CNT5 = 0;
`endif

  always #5 clk = ~clk;

  xdisp_arb #(.DEPTH(4), .GAP(2)) u_g2 (
    .clk(clk), .rst(rst),
    .req0_valid(v0[0]), .req0_data(d0[0]), .req0_ready(r0[0]),
    .req1_valid(v1[0]), .req1_data(d1[0]), .req1_ready(r1[0]),
    .disp_sel(sel[0]), .disp_data(dd[0]), .busy(bsy[0]), .char_cnt(cnt[0])
  );

  xdisp_arb #(.DEPTH(4), .GAP(3)) u_g3 (
    .clk(clk), .rst(rst),
    .req0_valid(v0[1]), .req0_data(d0[1]), .req0_ready(r0[1]),
    .req1_valid(v1[1]), .req1_data(d1[1]), .req1_ready(r1[1]),
    .disp_sel(sel[1]), .disp_data(dd[1]), .busy(bsy[1]), .char_cnt(cnt[1])
  );

  xdisp_arb #(.DEPTH(4), .GAP(0)) u_g0 (
    .clk(clk), .rst(rst),
    .req0_valid(v0[2]), .req0_data(d0[2]), .req0_ready(r0[2]),
    .req1_valid(v1[2]), .req1_data(d1[2]), .req1_ready(r1[2]),
    .disp_sel(sel[2]), .disp_data(dd[2]), .busy(bsy[2]), .char_cnt(cnt[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  int g0_sent = 0;
  int g0_np   = 0;

  // GAP=0 instance: req1 pushes up to 'upto' characters, pulses must be back to back
  task automatic run_g0(input int upto);
    int last;
    bit first;
    first = 1'b1;
    last  = 0;
    for (int c = 0; c < 40 && g0_np < upto; c++) begin
      v1[2] = (g0_sent < upto);
      d1[2] = 12'h0C1 + 12'(g0_sent);
      #1;
      if (sel[2]) begin
        chk("g0_data", 32'(dd[2]), 32'(12'h0C1 + 12'(g0_np)));
        if (!first) chk("g0_consecutive", 32'(c - last), 32'd1);
        first = 1'b0;
        last  = c;
        g0_np++;
      end
      if (v1[2] && r1[2]) g0_sent++;
      tick();
    end
    v1[2] = 1'b0;
    chk("g0_pulses", 32'(g0_np), 32'(upto));
  endtask

  initial begin
    logic [11:0] exp_alt [4];
    int a0, a1, acc_n, sunk;
    int occ, sent, npulse, last, stalls;
    bit push, pop, seen;

    exp_alt = '{12'h0A0, 12'h0B0, 12'h0A1, 12'h0B1};
    for (int i = 0; i < 3; i++) begin
      v0[i] = 1'b0; v1[i] = 1'b0; d0[i] = '0; d1[i] = '0;
    end

    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    v0[0] = 1'b1;
    v1[2] = 1'b1;
    #1;
    chk("rst_sel",   32'(sel[0]), 32'd0);
    chk("rst_data",  32'(dd[0]),  32'd0);
    chk("rst_busy",  32'(bsy[0]), 32'd0);
    chk("rst_cnt",   32'(cnt[0]), 32'd0);
    chk("rst_r0",    32'(r0[0]),  32'd1);
    chk("rst_r1_0",  32'(r1[0]),  32'd0);
    chk("rst_r0_g0", 32'(r0[2]),  32'd0);
    chk("rst_r1_g0", 32'(r1[2]),  32'd1);
    v0[0] = 1'b0;
    v1[2] = 1'b0;
    rst = 1'b0;
    tick();

    // single character latency and busy tail, GAP=2
    d0[0] = 12'h041;
    v0[0] = 1'b1;
    #1;
    chk("lat_ready", 32'(r0[0]), 32'd1);
    tick();
    v0[0] = 1'b0;
    chk("lat_sel_e1", 32'(sel[0]), 32'd0);
    chk("lat_busy_e1", 32'(bsy[0]), 32'd1);
    tick();
    chk("lat_sel", 32'(sel[0]), 32'd1);
    chk("lat_data", 32'(dd[0]), 32'h041);
    tick();
    chk("lat_sel_off", 32'(sel[0]), 32'd0);
    chk("lat_data_off", 32'(dd[0]), 32'd0);
    chk("lat_busy_w1", 32'(bsy[0]), 32'd1);
    tick();
    chk("lat_busy_w2", 32'(bsy[0]), 32'd1);
    tick();
    chk("lat_busy_done", 32'(bsy[0]), 32'd0);
    chk("lat_cnt", 32'(cnt[0]), 32'(EXP_CNT1));

    // both requesters valid: alternate 0,1,0,1 and sink order follows
    do_reset();
    a0 = 0; a1 = 0; acc_n = 0; sunk = 0;
    for (int c = 0; c < 60 && sunk < 4; c++) begin
      v0[0] = (a0 < 2);
      v1[0] = (a1 < 2);
      d0[0] = 12'h0A0 + 12'(a0);
      d1[0] = 12'h0B0 + 12'(a1);
      #1;
      if (r0[0] || r1[0]) begin
        chk("alt_who", 32'(r1[0]), 32'(acc_n % 2));
        chk("alt_exclusive", 32'(r0[0] & r1[0]), 32'd0);
        if (r0[0]) a0++;
        else       a1++;
        acc_n++;
      end
      tick();
      if (sel[0]) begin
        chk("alt_sink", 32'(dd[0]), 32'(exp_alt[sunk]));
        sunk++;
      end
    end
    v0[0] = 1'b0;
    v1[0] = 1'b0;
    chk("alt_accepted", 32'(acc_n), 32'd4);
    chk("alt_sunk", 32'(sunk), 32'd4);

    // burst of 6 into DEPTH=4 with GAP=3: stall while full, pulses every 5 cycles
    do_reset();
    occ = 0; sent = 0; npulse = 0; last = 0; stalls = 0;
    for (int c = 0; c < 80 && npulse < 6; c++) begin
      v0[1] = (sent < 6);
      d0[1] = 12'h100 + 12'(sent);
      #1;
      if (v0[1]) begin
        chk("burst_ready", 32'(r0[1]), 32'(occ < 4));
        if (!r0[1]) stalls++;
      end
      push = v0[1] && r0[1];
      pop  = sel[1];
      if (sel[1]) begin
        chk("burst_data", 32'(dd[1]), 32'(12'h100 + 12'(npulse)));
        if (npulse > 0) chk("burst_spacing", 32'(c - last), 32'd5);
        last = c;
        npulse++;
      end
      if (push) sent++;
      tick();
      occ = occ + int'(push) - int'(pop);
    end
    v0[1] = 1'b0;
    chk("burst_sent", 32'(sent), 32'd6);
    chk("burst_pulses", 32'(npulse), 32'd6);
    chk("burst_stalled", 32'(stalls > 0), 32'd1);

    // GAP=0: three queued characters drain on consecutive cycles
    do_reset();
    run_g0(3);
    chk("g0_sel_after", 32'(sel[2]), 32'd0);
    chk("g0_busy_after", 32'(bsy[2]), 32'd0);

    // two more characters bring the total sent to five
    run_g0(5);
    tick();
    chk("cnt_five", 32'(cnt[2]), 32'(EXP_CNT5));

    // reset during WAIT with two entries queued
    do_reset();
    sent = 0; seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      v0[0] = (sent < 3);
      d0[0] = 12'h0D0 + 12'(sent);
      #1;
      if (v0[0] && r0[0]) sent++;
      if (sel[0]) seen = 1'b1;
      tick();
    end
    v0[0] = 1'b0;
    chk("wrst_seen", 32'(seen), 32'd1);
    chk("wrst_busy_before", 32'(bsy[0]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("wrst_sel", 32'(sel[0]), 32'd0);
    chk("wrst_data", 32'(dd[0]), 32'd0);
    chk("wrst_busy", 32'(bsy[0]), 32'd0);
    chk("wrst_cnt", 32'(cnt[0]), 32'd0);
    tick();
    rst = 1'b0;
    npulse = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (sel[0]) npulse++;
    end
    chk("wrst_no_pulses", 32'(npulse), 32'd0);
    chk("wrst_idle_busy", 32'(bsy[0]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
